// File: rtl/forward_mix_input_ctrl_pkg.sv
// Shared definitions for the forward mix input selector: mode encoding,
// FSM state type and default element widths.
package mix_pkg;

    localparam int MODE_W      = 2;
    localparam int DEF_N_LEN_W = 16;
    localparam int DEF_N_LEN   = 24;

    typedef enum logic [MODE_W-1:0] {
        TRAIN    = 2'd0,
        FORWARD  = 2'd1,
        GEN_SIMI = 2'd2,
        GEN_NEW  = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_RAND = 2'd1,
        HOLD      = 2'd2
    } state_t;

endpackage

// File: rtl/forward_mix_input_ctrl_if.sv
// Request/operand/result bundle between the layer controller, the source
// buffers and the mix-layer MAC array.
interface forward_mix_input_ctrl_if
    import mix_pkg::*;
#(
    parameter int N       = 10,
    parameter int EMB_DIM = 24,
    parameter int HID_DIM = 24,
    parameter int N_LEN_W = DEF_N_LEN_W,
    parameter int N_LEN   = DEF_N_LEN,
    parameter int LAYERS  = 3
);
    localparam int LAY_W = (LAYERS > 1) ? $clog2(LAYERS) : 1;

    logic                                  req;
    logic [LAY_W-1:0]                      req_layer;
    logic [MODE_W-1:0]                     mode;
    logic [N*EMB_DIM*N_LEN_W-1:0]          d_emb;
    logic [HID_DIM*HID_DIM*N_LEN_W-1:0]    d_tanh;
    logic [HID_DIM*N_LEN_W-1:0]            d_rand;
    logic                                  rand_valid;
    logic                                  rand_ack;
    logic                                  busy;
    logic                                  err;
    logic                                  valid;
    logic                                  ready;
    logic [HID_DIM*HID_DIM*N_LEN-1:0]      q;

    modport master (
        output req, req_layer, mode, d_emb, d_tanh, d_rand, rand_valid, ready,
        input  rand_ack, busy, err, valid, q
    );

    modport slave (
        input  req, req_layer, mode, d_emb, d_tanh, d_rand, rand_valid, ready,
        output rand_ack, busy, err, valid, q
    );

endinterface

// File: rtl/forward_mix_input_ctrl_sat_add.sv
// Signed a + (b >>> 1) clamped to the W-bit two's-complement range.
module mix_sat_add #(
    parameter int W = 16
) (
    input  logic signed [W-1:0] a,
    input  logic signed [W-1:0] b,
    output logic signed [W-1:0] y
);
    logic signed [W:0] sum_s;

    // One guard bit holds the exact sum; halving b keeps it in range.
    assign sum_s = {a[W-1], a} + {{2{b[W-1]}}, b[W-1:1]};

    // Clamp when the guard bit disagrees with the narrow sign bit.
    always_comb begin
        if (sum_s[W] != sum_s[W-1]) begin
            if (sum_s[W]) begin
                y = {1'b1, {(W-1){1'b0}}};
            end else begin
                y = {1'b0, {(W-1){1'b1}}};
            end
        end else begin
            y = sum_s[W-1:0];
        end
    end

endmodule

// File: rtl/forward_mix_input_ctrl.sv
// Registered operand-matrix selector for the forward mix layers.
// Random perturbation (GEN_SIMI/GEN_NEW) is built only with FORWARD_MIX_RAND_EN.
module forward_mix_input_ctrl
    import mix_pkg::*;
#(
    parameter int N       = 10,
    parameter int EMB_DIM = 24,
    parameter int HID_DIM = 24,
    parameter int N_LEN_W = DEF_N_LEN_W,
    parameter int N_LEN   = DEF_N_LEN,
    parameter int LAYERS  = 3
) (
    input  logic clk,
    input  logic rst,
    forward_mix_input_ctrl_if.slave bus
);
    localparam int LAY_W = (LAYERS > 1) ? $clog2(LAYERS) : 1;
    localparam int Q_W   = HID_DIM * HID_DIM * N_LEN;

    state_t                             state_r;
    state_t                             next_s;
    logic [LAY_W-1:0]                   layer_r;
    logic [LAY_W-1:0]                   sel_layer_s;
    mode_t                              mode_r;
    mode_t                              sel_mode_s;
    logic                               accept_s;
    logic                               reject_s;
    logic                               need_rand_s;
    logic                               capture_s;
    logic                               consume_s;
    logic                               is_first_s;
    logic                               is_last_s;
    logic                               busy_r;
    logic                               valid_r;
    logic                               err_r;
    logic                               rand_ack_r;
    logic [Q_W-1:0]                     q_r;
    logic [Q_W-1:0]                     mat_s;
    logic signed [N_LEN_W-1:0]          elem_s;
    logic [HID_DIM-1:0][N_LEN_W-1:0]    hid_s;

    // Request classification: out-of-range layers are rejected, others accepted from IDLE.
    always_comb begin
        accept_s = 1'b0;
        reject_s = 1'b0;
        if (state_r == IDLE && bus.req) begin
            if (int'(bus.req_layer) >= LAYERS) begin
                reject_s = 1'b1;
            end else begin
                accept_s = 1'b1;
            end
        end else begin
            accept_s = 1'b0;
        end
    end

    // Layer/mode come straight from the request in IDLE, from the latched copy afterwards.
    always_comb begin
        if (state_r == IDLE) begin
            sel_layer_s = bus.req_layer;
            sel_mode_s  = mode_t'(bus.mode);
        end else begin
            sel_layer_s = layer_r;
            sel_mode_s  = mode_r;
        end
    end

    assign is_first_s = (sel_layer_s == '0);
    assign is_last_s  = (int'(sel_layer_s) == LAYERS - 1);

`ifdef FORWARD_MIX_RAND_EN
    assign need_rand_s = is_last_s && (sel_mode_s == GEN_SIMI || sel_mode_s == GEN_NEW);
`else
    assign need_rand_s = 1'b0;
    logic unused_rand_s;
    assign unused_rand_s = ^{sel_mode_s, bus.d_rand, bus.rand_valid};
`endif

    // Next-state and capture/consume strobes.
    always_comb begin
        next_s    = state_r;
        capture_s = 1'b0;
        consume_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (accept_s && need_rand_s) begin
                    next_s = WAIT_RAND;
                end else if (accept_s) begin
                    next_s    = HOLD;
                    capture_s = 1'b1;
                end else begin
                    next_s = IDLE;
                end
            end
`ifdef FORWARD_MIX_RAND_EN
            WAIT_RAND: begin
                if (bus.rand_valid) begin
                    next_s    = HOLD;
                    capture_s = 1'b1;
                    consume_s = 1'b1;
                end else begin
                    next_s = WAIT_RAND;
                end
            end
`endif
            HOLD: begin
                if (bus.ready) begin
                    next_s = IDLE;
                end else begin
                    next_s = HOLD;
                end
            end
            default: begin
                next_s = IDLE;
            end
        endcase
    end

    // Last-layer hidden vector: column 0 of tanh, optionally perturbed or replaced.
    for (genvar g = 0; g < HID_DIM; g++) begin : g_hid
        logic signed [N_LEN_W-1:0] tanh_s;
        assign tanh_s = bus.d_tanh[g*HID_DIM*N_LEN_W +: N_LEN_W];
`ifdef FORWARD_MIX_RAND_EN
        logic signed [N_LEN_W-1:0] rand_s;
        logic signed [N_LEN_W-1:0] sat_s;
        logic signed [N_LEN_W-1:0] pick_s;
        assign rand_s = bus.d_rand[g*N_LEN_W +: N_LEN_W];

        mix_sat_add #(.W(N_LEN_W)) u_sat (
            .a (tanh_s),
            .b (rand_s),
            .y (sat_s)
        );

        // Mode selects plain, perturbed or fully random hidden value.
        always_comb begin
            case (sel_mode_s)
                GEN_SIMI: pick_s = sat_s;
                GEN_NEW:  pick_s = rand_s;
                default:  pick_s = tanh_s;
            endcase
        end
        assign hid_s[g] = pick_s;
`else
        assign hid_s[g] = tanh_s;
`endif
    end

    // Element (i,j): padded embedding, full tanh, or the broadcast hidden row value.
    always_comb begin
        mat_s  = '0;
        elem_s = '0;
        for (int i = 0; i < HID_DIM; i++) begin
            for (int j = 0; j < HID_DIM; j++) begin
                if (is_first_s) begin
                    if (i < N) begin
                        elem_s = bus.d_emb[(((i < N) ? i : 0)*EMB_DIM + j)*N_LEN_W +: N_LEN_W];
                    end else begin
                        elem_s = '0;
                    end
                end else if (is_last_s) begin
                    elem_s = hid_s[i];
                end else begin
                    elem_s = bus.d_tanh[(i*HID_DIM + j)*N_LEN_W +: N_LEN_W];
                end
                mat_s[(i*HID_DIM + j)*N_LEN +: N_LEN] = N_LEN'(elem_s);
            end
        end
    end

    // State, handshake flags and the captured operand matrix.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            layer_r    <= '0;
            mode_r     <= TRAIN;
            busy_r     <= 1'b0;
            valid_r    <= 1'b0;
            err_r      <= 1'b0;
            rand_ack_r <= 1'b0;
            q_r        <= '0;
        end else begin
            state_r    <= next_s;
            busy_r     <= (next_s != IDLE);
            valid_r    <= (next_s == HOLD);
            err_r      <= reject_s;
            rand_ack_r <= consume_s;
            if (accept_s) begin
                layer_r <= bus.req_layer;
                mode_r  <= mode_t'(bus.mode);
            end
            if (capture_s) begin
                q_r <= mat_s;
            end
        end
    end

    assign bus.busy     = busy_r;
    assign bus.valid    = valid_r;
    assign bus.err      = err_r;
    assign bus.rand_ack = rand_ack_r;
    assign bus.q        = q_r;

endmodule

// File: tb/tb_forward_mix_input_ctrl.sv
// Scoreboard bench for forward_mix_input_ctrl; works with or without FORWARD_MIX_RAND_EN.
module tb_forward_mix_input_ctrl;
    import mix_pkg::*;

    localparam int N   = 10;
    localparam int EMB = 24;
    localparam int HID = 24;
    localparam int W   = 16;
    localparam int NL  = 24;
    localparam int L   = 3;
    localparam int QW  = HID * HID * NL;
    localparam int MAXV = (1 << (W - 1)) - 1;
    localparam int MINV = -(1 << (W - 1));

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    forward_mix_input_ctrl_if #(.N(N), .EMB_DIM(EMB), .HID_DIM(HID), .N_LEN_W(W),
                                .N_LEN(NL), .LAYERS(L)) ifc ();

    forward_mix_input_ctrl #(.N(N), .EMB_DIM(EMB), .HID_DIM(HID), .N_LEN_W(W),
                             .N_LEN(NL), .LAYERS(L)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    int emb [N][EMB];
    int tnh [HID][HID];
    int rnd [HID];
    logic [QW-1:0] exp_q [$];
    int n_cmp = 0;
    int n_fail = 0;
    int exp_ack = 0;
    int obs_ack = 0;
    int exp_err = 0;
    int obs_err = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_q(input string name, input logic [QW-1:0] act, input logic [QW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            for (int k = 0; k < HID*HID; k++) begin
                if (act[k*NL +: NL] !== exp[k*NL +: NL]) begin
                    $display("FAIL %s: element (%0d,%0d) got %h expected %h",
                             name, k / HID, k % HID, act[k*NL +: NL], exp[k*NL +: NL]);
                    break;
                end
            end
        end
    endtask

    function automatic int rand_w();
        case ($urandom_range(0, 5))
            0:       return MAXV;
            1:       return MINV;
            default: return int'($urandom_range(0, 65535)) - 32768;
        endcase
    endfunction

    task automatic fill_random();
        for (int i = 0; i < N; i++) for (int j = 0; j < EMB; j++) emb[i][j] = rand_w();
        for (int i = 0; i < HID; i++) for (int j = 0; j < HID; j++) tnh[i][j] = rand_w();
        for (int i = 0; i < HID; i++) rnd[i] = rand_w();
    endtask

    task automatic drive_data();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < EMB; j++) ifc.d_emb[(i*EMB + j)*W +: W] = W'(emb[i][j]);
        for (int i = 0; i < HID; i++)
            for (int j = 0; j < HID; j++) ifc.d_tanh[(i*HID + j)*W +: W] = W'(tnh[i][j]);
        for (int i = 0; i < HID; i++) ifc.d_rand[i*W +: W] = W'(rnd[i]);
    endtask

    function automatic int half_floor(input int v);
        if (v < 0 && (v % 2) != 0) return v / 2 - 1;
        return v / 2;
    endfunction

    function automatic int clamp_w(input int v);
        if (v > MAXV) return MAXV;
        if (v < MINV) return MINV;
        return v;
    endfunction

    // Reference: element values from the layer/mode rules, sign-extended to NL bits.
    function automatic logic [QW-1:0] model(input int layer, input int md);
        logic [QW-1:0] r;
        int v;
        int eff;
        r = '0;
        eff = md;
`ifndef FORWARD_MIX_RAND_EN
        if (eff >= 2) eff = 1;
`endif
        for (int i = 0; i < HID; i++) begin
            for (int j = 0; j < HID; j++) begin
                if (layer == 0) begin
                    if (i < N) v = emb[i][j];
                    else v = 0;
                end else if (layer == L - 1) begin
                    if (eff == 2) v = clamp_w(tnh[i][0] + half_floor(rnd[i]));
                    else if (eff == 3) v = rnd[i];
                    else v = tnh[i][0];
                end else begin
                    v = tnh[i][j];
                end
                r[(i*HID + j)*NL +: NL] = NL'(v);
            end
        end
        return r;
    endfunction

    // Monitor: pops the scoreboard on each transfer and checks q is stable while held.
    initial begin : monitor
        logic [QW-1:0] last_q;
        logic [QW-1:0] e;
        logic have_last;
        have_last = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                have_last = 1'b0;
            end else begin
                if (ifc.rand_ack) obs_ack++;
                if (ifc.err) obs_err++;
                if (ifc.valid) begin
                    if (have_last) chk_q("q_stable", ifc.q, last_q);
                    if (ifc.ready) begin
                        if (exp_q.size() == 0) begin
                            n_cmp++;
                            n_fail++;
                            $display("FAIL unexpected_transfer: got a transfer expected none");
                        end else begin
                            e = exp_q.pop_front();
                            chk_q("q_data", ifc.q, e);
                        end
                        have_last = 1'b0;
                    end else begin
                        last_q = ifc.q;
                        have_last = 1'b1;
                    end
                end else begin
                    have_last = 1'b0;
                end
            end
        end
    end

    // One request from IDLE to return to IDLE; starts and ends just after a falling edge.
    task automatic do_req(input int layer, input int md, input int rdelay, input int hold,
                          input bit scramble);
        bit is_err;
        bit need_rand;
        is_err = (layer >= L);
        need_rand = 1'b0;
`ifdef FORWARD_MIX_RAND_EN
        need_rand = !is_err && (layer == L - 1) && (md >= 2);
`endif
        drive_data();
        chk("idle_before_req", ifc.busy, 0);
        if (!is_err) exp_q.push_back(model(layer, md));
        ifc.req        = 1'b1;
        ifc.req_layer  = 2'(layer);
        ifc.mode       = 2'(md);
        ifc.ready      = 1'($urandom_range(0, 1));
        ifc.rand_valid = (rdelay < 0);
        @(negedge clk);
        ifc.req   = 1'b0;
        ifc.ready = 1'b0;
        if (!need_rand) ifc.rand_valid = 1'b0;
        if (is_err) begin
            chk("err_pulse", ifc.err, 1);
            chk("err_busy", ifc.busy, 0);
            chk("err_valid", ifc.valid, 0);
            exp_err++;
            @(negedge clk);
            chk("err_single", ifc.err, 0);
            return;
        end
        chk("busy_after_accept", ifc.busy, 1);
        if (need_rand) begin
            chk("wait_no_valid", ifc.valid, 0);
            chk("wait_no_ack", ifc.rand_ack, 0);
            for (int k = 0; k < rdelay; k++) begin
                @(negedge clk);
                chk("wait_hold", ifc.valid, 0);
            end
            ifc.rand_valid = 1'b1;
            @(negedge clk);
            ifc.rand_valid = 1'b0;
            chk("rand_ack_pulse", ifc.rand_ack, 1);
            exp_ack++;
        end else begin
            chk("no_rand_ack", ifc.rand_ack, 0);
        end
        chk("valid_after_capture", ifc.valid, 1);
        if (scramble) begin
            fill_random();
            drive_data();
        end
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            chk("valid_held", ifc.valid, 1);
        end
        ifc.ready = 1'b1;
        @(negedge clk);
        ifc.ready = 1'b0;
        chk("valid_drop", ifc.valid, 0);
        chk("busy_drop", ifc.busy, 0);
    endtask

    initial begin : stimulus
        rst = 1'b1;
        ifc.req = 1'b0;
        ifc.req_layer = '0;
        ifc.mode = '0;
        ifc.rand_valid = 1'b0;
        ifc.ready = 1'b0;
        fill_random();
        drive_data();
        repeat (2) @(negedge clk);
        chk("rst_busy", ifc.busy, 0);
        chk("rst_valid", ifc.valid, 0);
        chk("rst_ack", ifc.rand_ack, 0);
        chk("rst_err", ifc.err, 0);
        chk_q("rst_q", ifc.q, '0);
        rst = 1'b0;
        @(negedge clk);

        // Layer 0 with negative embeddings: rows past N stay zero.
        fill_random();
        for (int i = 0; i < N; i++) for (int j = 0; j < EMB; j++) emb[i][j] = -32767;
        do_req(0, int'(FORWARD), 0, 0, 1'b0);

        // Middle layer held for five cycles while sources change.
        for (int i = 0; i < HID; i++) for (int j = 0; j < HID; j++) tnh[i][j] = i*HID + j;
        do_req(1, int'(FORWARD), 0, 5, 1'b1);

        // Last layer broadcast in TRAIN.
        for (int i = 0; i < HID; i++) tnh[i][0] = i;
        do_req(2, int'(TRAIN), 0, 0, 1'b0);

        // Saturating perturbation with a late random sample.
        for (int i = 0; i < HID; i++) begin
            tnh[i][0] = 32'sh7F00;
            rnd[i] = 32'sh0400;
        end
        do_req(2, int'(GEN_SIMI), 3, 1, 1'b1);

        // Out-of-range layer.
        do_req(3, int'(FORWARD), 0, 0, 1'b0);

        // Reset while a random request is outstanding.
        fill_random();
        drive_data();
        ifc.req = 1'b1;
        ifc.req_layer = 2'(L - 1);
        ifc.mode = GEN_NEW;
        @(negedge clk);
        ifc.req = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", ifc.busy, 0);
        chk("mid_rst_valid", ifc.valid, 0);
        chk("mid_rst_ack", ifc.rand_ack, 0);
        chk_q("mid_rst_q", ifc.q, '0);
        @(negedge clk);
        rst = 1'b0;
        ifc.rand_valid = 1'b1;
        repeat (3) @(negedge clk);
        ifc.rand_valid = 1'b0;
        chk("post_rst_busy", ifc.busy, 0);
        chk("post_rst_valid", ifc.valid, 0);

        // GEN_NEW on the last layer; early rand_valid must wait for WAIT_RAND.
        fill_random();
        do_req(2, int'(GEN_NEW), -1, 0, 1'b1);

        // Random mix of layers, modes, sample delays and back-pressure.
        for (int it = 0; it < 40; it++) begin
            fill_random();
            do_req(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 4)) - 1, int'($urandom_range(0, 3)), 1'b1);
        end

        repeat (2) @(negedge clk);
        chk("ack_count", obs_ack, exp_ack);
        chk("err_count", obs_err, exp_err);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/forward_mix_input_ctrl.md
# forward_mix_input_ctrl

Parametrised, registered input selector for the forward mix layers, succeeding the combinational per-state selector. It accepts a layer request from the train/generation controller and builds the HID_DIM×HID_DIM operand matrix for that layer: zero-padded embeddings, previous tanh output, or a broadcast hidden vector. It optionally perturbs or replaces that vector with random samples, sign-extends to the wide datapath, and holds the result behind a valid/ready handshake. It sits between the embedding/tanh buffers and the mix-layer MAC array.

## Interface
- N, default 10: token count; rows of d_emb; N ≤ HID_DIM.
- EMB_DIM, default 24: embedding width; must equal HID_DIM.
- HID_DIM, default 24: matrix dimension.
- N_LEN_W, default 16: narrow fixed-point element width.
- N_LEN, default 24: wide output element width; N_LEN ≥ N_LEN_W.
- LAYERS, default 3: mix layer count; ≥ 2.
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  1  layer request; accepted when req & ~busy.
- req_layer  in  $clog2(LAYERS)  layer index; sampled on accept.
- mode  in  2  TRAIN=0, FORWARD=1, GEN_SIMI=2, GEN_NEW=3; sampled on accept.
- d_emb  in  N*EMB_DIM*N_LEN_W  embedding matrix, row-major.
- d_tanh  in  HID_DIM*HID_DIM*N_LEN_W  previous tanh output, row-major.
- d_rand  in  HID_DIM*N_LEN_W  random vector.
- rand_valid  in  1  d_rand holds a fresh sample.
- rand_ack  out  1  one-cycle pulse when d_rand is consumed.
- busy  out  1  high outside IDLE.
- err  out  1  one-cycle pulse on a rejected request.
- valid  out  1  q holds a result.
- ready  in  1  consumer accepts q.
- q  out  HID_DIM*HID_DIM*N_LEN  registered, sign-extended output matrix.

## Operation
- FSM states: IDLE, WAIT_RAND, HOLD.
- IDLE + req with req_layer ≥ LAYERS: request is not accepted; err pulses next cycle; FSM stays in IDLE.
- IDLE + valid req: sample req_layer and mode.
  - If the request needs random data: go to WAIT_RAND.
  - Otherwise: capture q; go to HOLD.
- Source by layer:
  - Layer 0: d_emb in rows 0..N-1; rows N..HID_DIM-1 are zero.
  - Layers 1..LAYERS-2: d_tanh.
  - Layer LAYERS-1: broadcast. Hidden element h[i] = d_tanh element (i,0); q(i,j) = h[i] for all j.
- Last-layer hidden vector by mode:
  - TRAIN or FORWARD: h[i] = tanh(i,0).
  - GEN_SIMI: h[i] = sat(tanh(i,0) + (rand[i] >>> 1)), arithmetic shift; result saturates to the N_LEN_W signed range.
  - GEN_NEW: h[i] = rand[i].
- WAIT_RAND: remains until rand_valid. On rand_valid: capture q, pulse rand_ack, go to HOLD.
- HOLD: valid=1 and q stable. On ready: valid drops next cycle; go to IDLE.
- Requests while busy are ignored. They are not queued and do not raise err.
- Output element = N_LEN_W value sign-extended to N_LEN.
- Changes on d_emb/d_tanh/d_rand after capture do not affect q.

## Timing
- Reset values: busy=0, valid=0, rand_ack=0, err=0, q=0; FSM in IDLE.
- Non-random request accepted at edge T: valid=1 and q updated after T. First transfer is possible at edge T+1.
- Random request: q captured at the first edge where rand_valid=1 in WAIT_RAND; valid=1 after that edge.
- Throughput: at most one result per 2 cycles, since IDLE is always visited between results.
- ready while valid=0 has no effect.
- rst asserted mid-operation: immediate return to reset values. An in-flight random request is dropped without rand_ack.
- rand_valid and req arriving in the same cycle in IDLE: rand_valid is not consumed that cycle. Consumption happens only from WAIT_RAND.

## Configuration
- FORWARD_MIX_RAND_EN defined: GEN_SIMI/GEN_NEW behave as above; WAIT_RAND exists.
- FORWARD_MIX_RAND_EN undefined:
  - GEN_SIMI/GEN_NEW behave as FORWARD.
  - WAIT_RAND, the saturating adder and rand_ack logic are removed; rand_ack is tied to 0.
  - d_rand and rand_valid remain as ports and are ignored.

## Structure
- Shared package mix_pkg holds:
  - the mode encoding (TRAIN, FORWARD, GEN_SIMI, GEN_NEW) and its 2-bit width;
  - the FSM state typedef;
  - the default widths N_LEN_W/N_LEN.
- Sub-module mix_sat_add: one N_LEN_W signed adder computing a + (b>>>1) with saturation. It is instantiated HID_DIM times, only under FORWARD_MIX_RAND_EN.

## Test plan
- Layer 0, FORWARD, d_emb all 16'h8001, ready=1 → one valid cycle. Rows 0..9 = 24'hFF8001; rows 10..23 = 0; busy=0 two cycles after accept.
- Layer 1, d_tanh element (i,j) = i*24+j, ready low for 5 cycles → valid held 5 cycles. q stable while d_tanh changes; transfer on the ready edge.
- Layer 2, TRAIN, d_tanh(i,0)=i → every q(i,j)=i. No rand_ack, no wait on rand_valid.
- Layer 2, GEN_SIMI, tanh(i,0)=16'h7F00, rand=16'h0400, rand_valid raised 3 cycles after accept → result is 16'h7FFF (saturated), zero-extended as 24'h007FFF. rand_ack pulses once; valid follows.
- req_layer=3 with LAYERS=3 → err pulse, busy stays 0, no valid. Then rst pulsed in WAIT_RAND → all outputs 0; a later rand_valid produces no rand_ack.
- FORWARD_MIX_RAND_EN undefined, layer 2, GEN_NEW → q equals the TRAIN result; rand_ack stays 0.
